// File: rtl/y86_mem_pkg.sv
// Shared constants and types for the y86-64 data-memory path.
package y86_mem_pkg;

    localparam int DMEM_DEPTH      = 1024;
    localparam int DMEM_STACK_BASE = 960;
    localparam int WORD_W          = 64;

    // Instruction codes that reach the data memory from the M stage.
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Responder sequencing: wait for a request, count out the latency, hold the response.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage: synchronous write port and registered read port sharing one enable.
module dmem_array
    import y86_mem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Either write the word or capture it into the read register; never both.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: one outstanding request, fixed latency.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// req_ready is high only in IDLE (and never while rst_n is low); rsp_valid is high
// only in RESP, with rdata/error/stack held stable until rsp_ready is seen.
module dmem_responder
    import y86_mem_pkg::*;
#(
    parameter int DEPTH      = DMEM_DEPTH,
    parameter int LATENCY    = 2,
    parameter int STACK_BASE = DMEM_STACK_BASE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              rsp_stack,
    output dmem_state_e       dbg_state
);

    localparam int AW = $clog2(DEPTH);
    // Counter only has to hold LATENCY-1.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_e       state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic              wr_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              err_q;
    logic              stack_q;
    logic              rd_ok_q;
    logic [WORD_W-1:0] arr_rdata;

    logic accept;
    logic access;
    logic addr_err;
    logic arr_en;

    assign accept   = req_valid && req_ready;
    assign access   = (state_q == ACCESS) && (cnt_q == '0);
    // Full-width compare: high address bits must never alias into the array.
    assign addr_err = (addr_q >= WORD_W'(DEPTH));
    // A reset on the access edge drops the pending access.
    assign arr_en   = rst_n && access && !addr_err;

    // Next-state and request-side handshake.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = rst_n;
                if (req_valid && rst_n) state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == '0) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Latency counter: loaded on acceptance, counts down while in ACCESS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= CW'(LATENCY - 1);
        end else if ((state_q == ACCESS) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Request fields are captured only at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Response flags are computed at the access edge and held through RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q   <= 1'b0;
            stack_q <= 1'b0;
            rd_ok_q <= 1'b0;
        end else if (access) begin
            err_q   <= addr_err;
            stack_q <= !addr_err && (addr_q >= WORD_W'(STACK_BASE));
            rd_ok_q <= !addr_err && !wr_q;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (wr_q),
        .addr  (addr_q[AW-1:0]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    // Writes and errors report zero data; the array's read register is not reset.
    assign rsp_rdata = rd_ok_q ? arr_rdata : '0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_error = err_q;
    assign rsp_stack = stack_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a word-map reference model.
module tb_dmem_responder;
  import y86_mem_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;
  localparam int SBASE = 960;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_stack;
  dmem_state_e dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: written words only; unwritten words have unknown contents.
  logic [63:0] model [logic [63:0]];
  // Expected response entries: {known, stack, error, rdata}.
  logic [66:0] exp_q[$];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .STACK_BASE(SBASE)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_stack(rsp_stack), .dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One complete transaction: request, latency check, optional hold, consume.
  task automatic transact(input logic w, input logic [63:0] a, input logic [63:0] d,
                          input int hold, input bit keep_valid, output int acc_cyc);
    logic [66:0] e;
    logic exp_err, exp_stk, known;
    logic [63:0] exp_rd;
    int n;
    exp_err = (a >= 64'(DEPTH));
    exp_stk = !exp_err && (a >= 64'(SBASE));
    exp_rd  = '0;
    known   = 1'b1;
    if (!w && !exp_err) begin
      if (model.exists(a)) exp_rd = model[a];
      else known = 1'b0;
    end
    if (w && !exp_err) model[a] = d;
    exp_q.push_back({known, exp_stk, exp_err, exp_rd});

    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    rsp_ready = keep_valid;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL accept_timeout addr=%h got req_ready=%b want 1", a, req_ready); end
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!keep_valid) req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};

    for (int k = 0; k < LAT; k++) begin
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
        failures++; $display("FAIL busy_early k=%0d got rsp_valid=%b req_ready=%b want 0/0", k, rsp_valid, req_ready);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rsp_latency addr=%h got rsp_valid=%b want 1", a, rsp_valid); end

    e = exp_q.pop_front();
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin @(posedge clk); #1; end
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
        failures++; $display("FAIL rsp_hold h=%0d got rsp_valid=%b req_ready=%b want 1/0", h, rsp_valid, req_ready);
      end
      checks++;
      if (rsp_error !== e[64] || rsp_stack !== e[65]) begin
        failures++; $display("FAIL rsp_flags addr=%h got err=%b stk=%b want err=%b stk=%b", a, rsp_error, rsp_stack, e[64], e[65]);
      end
      if (e[66]) begin
        checks++;
        if (rsp_rdata !== e[63:0]) begin
          failures++; $display("FAIL rsp_rdata addr=%h got %h want %h", a, rsp_rdata, e[63:0]);
        end
      end
    end

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL rsp_consume got rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
    end
    rsp_ready = keep_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 64'h0 || rsp_error !== 1'b0 || rsp_stack !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got rdy=%b vld=%b rd=%h err=%b stk=%b want all 0", req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_stack);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release got req_ready=%b want 1", req_ready); end
  endtask

  task automatic test_write_read();
    int t;
    transact(1'b1, 64'd5, 64'h1122334455667788, 0, 1'b0, t);
    transact(1'b0, 64'd5, 64'h0, 0, 1'b0, t);
  endtask

  task automatic test_range();
    int t;
    transact(1'b1, 64'd1023, 64'hA5A5_0000_5A5A_1023, 0, 1'b0, t);
    transact(1'b1, 64'd1024, 64'hDEAD, 0, 1'b0, t);
    transact(1'b0, 64'd1023, 64'h0, 0, 1'b0, t);
    transact(1'b0, 64'h1_0000_0005, 64'h0, 0, 1'b0, t);
    transact(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 1'b0, t);
  endtask

  task automatic test_stack_hold();
    int t;
    transact(1'b1, 64'd960, 64'd7, 5, 1'b0, t);
    transact(1'b0, 64'd960, 64'h0, 2, 1'b0, t);
    transact(1'b0, 64'd959, 64'h0, 0, 1'b0, t);
  endtask

  task automatic test_reset_midop();
    int t;
    transact(1'b1, 64'd3, 64'h3333, 0, 1'b0, t);
    // Accept a write to 3, then reset before its access edge.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd3; req_wdata = 64'h9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 64'h0 || rsp_error !== 1'b0 || rsp_stack !== 1'b0) begin
        failures++; $display("FAIL midop_reset_outputs got rdy=%b vld=%b rd=%h err=%b stk=%b want all 0", req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_stack);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL midop_no_stale got rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
    end
    transact(1'b0, 64'd3, 64'h0, 0, 1'b0, t);
    // A held response is discarded by reset.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'd961; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_stack !== 1'b0) begin
      failures++; $display("FAIL held_rsp_discard got rsp_valid=%b rsp_stack=%b want 0/0", rsp_valid, rsp_stack);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int prev, cur;
    logic [63:0] a;
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      a = (i < 4) ? 64'(16 + i) : 64'(16 + i - 4);
      transact(i < 4, a, {$urandom, $urandom}, 0, 1'b1, cur);
      if (prev >= 0) begin
        checks++;
        if (cur - prev != LAT + 2) begin
          failures++; $display("FAIL b2b_spacing i=%0d got %0d cycles want %0d", i, cur - prev, LAT + 2);
        end
      end
      prev = cur;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    int t;
    logic [63:0] a;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: a = 64'($urandom_range(0, 15));
        1: a = 64'($urandom_range(0, DEPTH - 1));
        2: a = 64'($urandom_range(SBASE - 2, SBASE + 2));
        3: a = 64'($urandom_range(DEPTH - 2, DEPTH + 1));
        4: a = {32'($urandom_range(1, 255)), 32'($urandom_range(0, 15))};
        default: a = 64'($urandom_range(0, 7));
      endcase
      transact(1'($urandom), a, {$urandom, $urandom}, $urandom_range(0, 2), 1'b0, t);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_range();
    test_stack_hold();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Clocked data-memory responder for the pipelined y86-64 core.
- Services one memory request at a time from the M-stage initiator: a read for mrmovq/popq/ret, or a write for rmmovq/pushq/call.
- Uses a valid/ready request channel, a fixed programmable access latency, and a valid/ready response channel.
- Returns read data and an address-error flag that feeds dmem_error/stat.

Parameters:
- DEPTH, 1024: number of 64-bit words; addresses are word indices.
- LATENCY, 2: cycles from request acceptance to response valid; must be >= 1.
- STACK_BASE, 960: first word of the reserved stack region (DEPTH-64).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = write (rmmovq/pushq/call), 0 = read.
- req_addr  input  64  word address.
- req_wdata  input  64  write data (valA or valP).
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator consumes the response.
- rsp_rdata  output  64  read data (valM); 0 for writes and errors.
- rsp_error  output  1  address out of range (dmem_error).
- rsp_stack  output  1  accessed address is in [STACK_BASE, DEPTH-1].

Behaviour:
- Reset (rst_n low at a rising edge):
  - state goes to IDLE; latency counter goes to 0.
  - req_ready is 0 while rst_n is low, then 1 in IDLE.
  - rsp_valid, rsp_rdata, rsp_error and rsp_stack all go to 0.
  - Memory contents are not cleared.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch write, addr and wdata; load counter with LATENCY-1; go to ACCESS.
- ACCESS:
  - req_ready = 0.
  - If counter != 0, decrement it.
  - If counter == 0, perform the access at this edge and go to RESP.
- Access rules:
  - Error when addr >= DEPTH, comparing the full 64-bit unsigned value; upper bits are never truncated.
  - On error: no write occurs, rsp_rdata = 0, rsp_error = 1.
  - Valid write: mem[addr] <= wdata; rsp_rdata = 0; rsp_error = 0.
  - Valid read: rsp_rdata <= mem[addr]; rsp_error = 0.
  - rsp_stack = !error && addr >= STACK_BASE.
- RESP:
  - rsp_valid = 1; rsp_rdata, rsp_error and rsp_stack held stable.
  - On rsp_ready: rsp_valid clears at that edge and the state returns to IDLE.
  - The next request can be accepted no earlier than the cycle after the response is consumed; there is no bypass.
  - rsp_ready while rsp_valid = 0 is ignored.
- Latency: request accepted at edge T; rsp_valid is first high after edge T+LATENCY. Back-to-back throughput is LATENCY+2 cycles per request.
- Only one request is ever outstanding, so there are no read/write ordering hazards.
- Reset mid-operation:
  - A pending write whose access edge has not yet occurred is dropped; memory keeps its old value.
  - A held response is discarded.
- Request inputs are sampled only at the acceptance edge; changes afterwards have no effect.
- LATENCY = 1: ACCESS lasts exactly one cycle.

Decomposition:
- Package y86_mem_pkg holds:
  - constants DMEM_DEPTH = 1024, DMEM_STACK_BASE = 960, WORD_W = 64;
  - y86 icode localparams (IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9, IPUSHQ=10, IPOPQ=11);
  - the state encoding enum {IDLE, ACCESS, RESP}.
- One sub-module, dmem_array: DEPTH x 64 storage with a synchronous write port and a synchronous registered read port, enabled only on the access edge.
- dmem_responder holds the FSM, counter, range check and response registers.

Test Plan:
- Reset, then write addr 5 data 0x1122334455667788, then read addr 5 (LATENCY=2) -> each rsp_valid first rises 2 edges after acceptance; read rsp_rdata=0x1122334455667788, rsp_error=0.
- Write addr 1024 data 0xDEAD, then read addr 1023 -> write response rsp_error=1 and rsp_rdata=0; addr 1023 is unchanged (initial content); read rsp_error=0.
- Read addr 0x1_0000_0005, which aliases 5 in the low bits -> rsp_error=1, rsp_rdata=0 (no truncation).
- Write addr 960 data 7 with rsp_ready held low 5 cycles -> rsp_valid stays high and stable; rsp_stack=1; req_ready=0 throughout; acceptance only after rsp_ready.
- Accept write addr 3 data 9 (LATENCY=4), pull rst_n low 2 cycles later, release, then read addr 3 -> old value returned and no stale response; all outputs 0 during reset.
- Back-to-back requests with req_valid held high and rsp_ready tied 1 -> one acceptance every LATENCY+2 cycles; request fields changed after acceptance are ignored.
